// File: rtl/wb_ctram_arbiter_if.sv
// Wishbone bundle joining the tile CTRAM masters, the round-robin arbiter and
// the shared memory slave.
`timescale 1ns/1ps
interface wb_ctram_arbiter_if #(
  parameter int MASTERS = 3
);
  logic [MASTERS*32-1:0] m_adr_i;
  logic [MASTERS*32-1:0] m_dat_i;
  logic [MASTERS*4-1:0]  m_sel_i;
  logic [MASTERS*3-1:0]  m_cti_i;
  logic [MASTERS*2-1:0]  m_bte_i;
  logic [MASTERS-1:0]    m_cyc_i;
  logic [MASTERS-1:0]    m_stb_i;
  logic [MASTERS-1:0]    m_we_i;
  logic [MASTERS-1:0]    m_ack_o;
  logic [MASTERS-1:0]    m_rty_o;
  logic [MASTERS-1:0]    m_err_o;
  logic [MASTERS*32-1:0] m_dat_o;

  logic [31:0]           s_adr_o;
  logic [31:0]           s_dat_o;
  logic [3:0]            s_sel_o;
  logic [2:0]            s_cti_o;
  logic [1:0]            s_bte_o;
  logic                  s_cyc_o;
  logic                  s_stb_o;
  logic                  s_we_o;
  logic                  s_ack_i;
  logic                  s_rty_i;
  logic                  s_err_i;
  logic [31:0]           s_dat_i;

  // The arbiter's own view: requests in from the tiles, one request out to memory.
  modport arbiter (
    input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i, m_we_i,
    output m_ack_o, m_rty_o, m_err_o, m_dat_o,
    output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o, s_we_o,
    input  s_ack_i, s_rty_i, s_err_i, s_dat_i
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i, m_we_i,
    input  m_ack_o, m_rty_o, m_err_o, m_dat_o
  );

  modport slave (
    input  s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o, s_we_o,
    output s_ack_i, s_rty_i, s_err_i, s_dat_i
  );
endinterface

// File: rtl/wb_ctram_arbiter.sv
// Round-robin Wishbone arbiter sharing one memory slave among the CTRAM masters,
// with whole-tenure ownership and a watchdog that aborts hung transfers.
`timescale 1ns/1ps
module wb_ctram_arbiter #(
  parameter int MASTERS  = 3,
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_ctram_arbiter_if.arbiter bus,
  output logic [MASTERS-1:0]  grant_o,
  output logic                timeout_o
);
  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [MASTERS-1:0]  grant_q, grant_d;
  logic [IW-1:0]       last_q, last_d;
  logic [TO_WIDTH-1:0] count_q, count_d;
  logic                abort_q, abort_d;

  logic [IW-1:0]       winner;
  logic                any_req;
  logic                resp;
  logic                stall;
  logic                wd_fire;

  logic                cur_cyc, cur_stb, cur_we;
  logic [31:0]         cur_adr, cur_dat;
  logic [3:0]          cur_sel;
  logic [2:0]          cur_cti;
  logic [1:0]          cur_bte;

  logic [MASTERS-1:0]  ack, rty, err;
  logic                s_cyc, s_stb, s_we;
  logic [31:0]         s_adr, s_dat;
  logic [3:0]          s_sel;
  logic [2:0]          s_cti;
  logic [1:0]          s_bte;

  // Lowest requester above the last winner, else wrap to the lowest requester overall.
  always_comb begin
    winner = last_q;
    for (int k = MASTERS - 1; k >= 0; k--) begin
      if (bus.m_cyc_i[k]) winner = IW'(k);
    end
    for (int k = MASTERS - 1; k >= 0; k--) begin
      if (bus.m_cyc_i[k] && (k > int'(last_q))) winner = IW'(k);
    end
  end

  assign any_req = |bus.m_cyc_i;

  // last_q doubles as the owner index for the whole tenure.
  always_comb begin
    cur_cyc = 1'b0;
    cur_stb = 1'b0;
    cur_we  = 1'b0;
    cur_adr = '0;
    cur_dat = '0;
    cur_sel = '0;
    cur_cti = '0;
    cur_bte = '0;
    for (int k = 0; k < MASTERS; k++) begin
      if (last_q == IW'(k)) begin
        cur_cyc = bus.m_cyc_i[k];
        cur_stb = bus.m_stb_i[k];
        cur_we  = bus.m_we_i[k];
        cur_adr = bus.m_adr_i[k*32 +: 32];
        cur_dat = bus.m_dat_i[k*32 +: 32];
        cur_sel = bus.m_sel_i[k*4 +: 4];
        cur_cti = bus.m_cti_i[k*3 +: 3];
        cur_bte = bus.m_bte_i[k*2 +: 2];
      end
    end
  end

  assign resp    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign stall   = (state_q == GRANT) && cur_stb && !resp;
  assign wd_fire = (TIMEOUT != 0) && stall && (count_q == TO_WIDTH'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = '0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          last_d          = winner;
          state_d         = GRANT;
        end
      end
      GRANT: begin
        if (!cur_cyc) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (wd_fire) begin
          abort_d = 1'b1;
          state_d = ABORT;
        end else if (stall && (TIMEOUT != 0)) begin
          count_d = count_q + TO_WIDTH'(1);
        end
      end
      ABORT: begin
        if (!cur_cyc) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // While aborting, the slave sees nothing and late responses never reach the master.
  always_comb begin
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    s_adr = '0;
    s_dat = '0;
    s_sel = '0;
    s_cti = '0;
    s_bte = '0;
    ack   = '0;
    rty   = '0;
    err   = '0;
    if (state_q == GRANT) begin
      s_cyc = cur_cyc;
      s_stb = cur_stb;
      s_we  = cur_we;
      s_adr = cur_adr;
      s_dat = cur_dat;
      s_sel = cur_sel;
      s_cti = cur_cti;
      s_bte = cur_bte;
      for (int k = 0; k < MASTERS; k++) begin
        if (last_q == IW'(k)) begin
          ack[k] = bus.s_ack_i;
          rty[k] = bus.s_rty_i;
          err[k] = bus.s_err_i;
        end
      end
    end else if (state_q == ABORT) begin
      for (int k = 0; k < MASTERS; k++) begin
        if (last_q == IW'(k)) err[k] = abort_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(MASTERS - 1);
      count_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
      abort_q <= abort_d;
    end
  end

  assign bus.s_cyc_o = s_cyc;
  assign bus.s_stb_o = s_stb;
  assign bus.s_we_o  = s_we;
  assign bus.s_adr_o = s_adr;
  assign bus.s_dat_o = s_dat;
  assign bus.s_sel_o = s_sel;
  assign bus.s_cti_o = s_cti;
  assign bus.s_bte_o = s_bte;
  assign bus.m_ack_o = ack;
  assign bus.m_rty_o = rty;
  assign bus.m_err_o = err;
  assign bus.m_dat_o = {MASTERS{bus.s_dat_i}};

  assign grant_o   = grant_q;
  assign timeout_o = abort_q;
endmodule

// File: tb/tb_wb_ctram_arbiter.sv
// Bench for wb_ctram_arbiter: directed scenarios followed by random traffic
// compared against a tenure-level reference model.
`timescale 1ns/1ps
module tb_wb_ctram_arbiter;
  localparam int M  = 3;
  localparam int TO = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [M-1:0] grant;
  logic         timeout;
  int           compared   = 0;
  int           mismatched = 0;
  int           silent     = 0;
  int           aborts     = 0;

  // Reference model: who owns the slave, round-robin pointer, unanswered strobe run.
  int owner   = -1;
  int last    = M - 1;
  int run     = 0;
  bit aborted = 1'b0;
  bit errnow  = 1'b0;

  always #5 clk = ~clk;

  wb_ctram_arbiter_if #(.MASTERS(M)) bus ();

  wb_ctram_arbiter #(.MASTERS(M), .TIMEOUT(TO), .TO_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyStimulus(input int i, input bit cyc, input bit stb,
                               input logic [31:0] adr, input logic [2:0] cti);
    bus.m_cyc_i[i]         = cyc;
    bus.m_stb_i[i]         = stb;
    bus.m_we_i[i]          = 1'b0;
    bus.m_adr_i[i*32 +: 32] = adr;
    bus.m_dat_i[i*32 +: 32] = ~adr;
    bus.m_sel_i[i*4 +: 4]   = 4'hF;
    bus.m_cti_i[i*3 +: 3]   = cti;
    bus.m_bte_i[i*2 +: 2]   = 2'b00;
  endtask

  task automatic slaveResp(input bit ack, input bit err, input bit rty, input logic [31:0] dat);
    bus.s_ack_i = ack;
    bus.s_err_i = err;
    bus.s_rty_i = rty;
    bus.s_dat_i = dat;
  endtask

  task automatic clearAll();
    for (int i = 0; i < M; i++) applyStimulus(i, 1'b0, 1'b0, 32'h0, 3'b000);
    slaveResp(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic doReset();
    clearAll();
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    owner   = -1;
    last    = M - 1;
    run     = 0;
    aborted = 1'b0;
    errnow  = 1'b0;
  endtask

  task automatic randomCycle();
    logic [M-1:0]   eg, eack, eerr, erty;
    logic [31:0]    eadr, edat;
    logic [3:0]     esel;
    logic [4:0]     ectl;
    logic [2:0]     eflags;
    logic           etimeout;
    bit             c;
    int             r;
    int             pick;
    tick();
    for (int i = 0; i < M; i++) begin
      c = bus.m_cyc_i[i];
      c = c ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) == 0);
      bus.m_cyc_i[i]          = c;
      bus.m_stb_i[i]          = c && ($urandom_range(0, 15) != 0);
      bus.m_we_i[i]           = ($urandom_range(0, 1) == 1);
      bus.m_adr_i[i*32 +: 32] = $urandom;
      bus.m_dat_i[i*32 +: 32] = $urandom;
      bus.m_sel_i[i*4 +: 4]   = 4'($urandom_range(0, 15));
      bus.m_cti_i[i*3 +: 3]   = 3'($urandom_range(0, 7));
      bus.m_bte_i[i*2 +: 2]   = 2'($urandom_range(0, 3));
    end
    if (silent > 0) begin
      silent--;
      slaveResp(1'b0, 1'b0, 1'b0, $urandom);
    end else if ($urandom_range(0, 29) == 0) begin
      silent = $urandom_range(8, 24);
      slaveResp(1'b0, 1'b0, 1'b0, $urandom);
    end else begin
      r = $urandom_range(0, 15);
      slaveResp(r < 8, r == 8, r == 9, $urandom);
    end
    settle();

    eg = '0; eack = '0; eerr = '0; erty = '0;
    eadr = '0; edat = '0; esel = '0; ectl = '0; eflags = '0; etimeout = 1'b0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      if (!aborted) begin
        eflags      = {bus.m_cyc_i[owner], bus.m_stb_i[owner], bus.m_we_i[owner]};
        eadr        = bus.m_adr_i[owner*32 +: 32];
        edat        = bus.m_dat_i[owner*32 +: 32];
        esel        = bus.m_sel_i[owner*4 +: 4];
        ectl        = {bus.m_cti_i[owner*3 +: 3], bus.m_bte_i[owner*2 +: 2]};
        eack[owner] = bus.s_ack_i;
        eerr[owner] = bus.s_err_i;
        erty[owner] = bus.s_rty_i;
      end else begin
        eerr[owner] = errnow;
        etimeout    = errnow;
      end
    end
    checkOutput("rnd_grant", grant, eg);
    checkOutput("rnd_cyc_stb_we", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}, eflags);
    if (!aborted) begin
      checkOutput("rnd_s_adr", bus.s_adr_o, eadr);
      checkOutput("rnd_s_dat", bus.s_dat_o, edat);
      checkOutput("rnd_s_sel", bus.s_sel_o, esel);
      checkOutput("rnd_s_cti_bte", {bus.s_cti_o, bus.s_bte_o}, ectl);
    end
    checkOutput("rnd_m_ack", bus.m_ack_o, eack);
    checkOutput("rnd_m_err", bus.m_err_o, eerr);
    checkOutput("rnd_m_rty", bus.m_rty_o, erty);
    checkOutput("rnd_timeout", timeout, etimeout);
    checkOutput("rnd_m_dat", bus.m_dat_o, {M{bus.s_dat_i}});

    // Advance the model across the coming clock edge using the inputs now applied.
    if (owner < 0) begin
      pick = -1;
      for (int k = 1; k <= M; k++) begin
        if (pick < 0 && bus.m_cyc_i[(last + k) % M]) pick = (last + k) % M;
      end
      if (pick >= 0) begin
        owner   = pick;
        last    = pick;
        run     = 0;
        aborted = 1'b0;
      end
    end else if (!aborted) begin
      if (!bus.m_cyc_i[owner]) begin
        owner = -1;
      end else if (bus.m_stb_i[owner] && !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i)) begin
        run++;
        if (run == TO) begin
          aborted = 1'b1;
          errnow  = 1'b1;
          run     = 0;
          aborts++;
        end
      end else begin
        run = 0;
      end
    end else begin
      errnow = 1'b0;
      if (!bus.m_cyc_i[owner]) begin
        owner   = -1;
        aborted = 1'b0;
      end
    end
  endtask

  initial begin : main
    int             seen[$];
    int             gaps[$];
    bit             drop [M];
    int             zero_run;
    logic [M-1:0]   prev;
    int             idx;

    // Reset values while rst_n is held low.
    clearAll();
    #2;
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_s_cyc_stb_we", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}, 0);
    checkOutput("rst_s_adr_dat", {bus.s_adr_o, bus.s_dat_o}, 0);
    checkOutput("rst_m_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
    checkOutput("rst_m_dat", bus.m_dat_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single read by master 1.
    tick();
    applyStimulus(1, 1'b1, 1'b1, 32'h100, 3'b000);
    settle();
    checkOutput("t1_no_grant_yet", grant, 0);
    tick(); settle();
    checkOutput("t1_grant", grant, 3'b010);
    checkOutput("t1_s_cyc", bus.s_cyc_o, 1);
    checkOutput("t1_s_adr", bus.s_adr_o, 32'h100);
    tick(); settle();
    tick();
    slaveResp(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    settle();
    checkOutput("t1_ack", bus.m_ack_o, 3'b010);
    checkOutput("t1_rdata", bus.m_dat_o[32 +: 32], 32'hDEADBEEF);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 3'b000);
    slaveResp(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("t1_ack_clear", bus.m_ack_o, 0);
    tick(); settle();
    checkOutput("t1_released", grant, 0);

    // Round robin: every master requests again right after its single access.
    doReset();
    zero_run = 0;
    prev     = '0;
    for (int i = 0; i < M; i++) drop[i] = 1'b0;
    for (int c = 0; c < 60 && seen.size() < 6; c++) begin
      tick();
      for (int i = 0; i < M; i++) applyStimulus(i, !drop[i], !drop[i], 32'h200 + i, 3'b000);
      #1;
      slaveResp(bus.s_stb_o, 1'b0, 1'b0, 32'h1000 + c);
      #1;
      if (grant != '0 && prev == '0) begin
        idx = -1;
        for (int i = 0; i < M; i++) if (grant[i]) idx = i;
        seen.push_back(idx);
        if (seen.size() > 1) gaps.push_back(zero_run);
      end
      zero_run = (grant == '0) ? zero_run + 1 : 0;
      prev = grant;
      for (int i = 0; i < M; i++) drop[i] = bus.m_ack_o[i];
    end
    checkOutput("rr_tenures", seen.size(), 6);
    for (int j = 0; j < seen.size(); j++) checkOutput($sformatf("rr_order%0d", j), seen[j], j % M);
    for (int j = 0; j < gaps.size(); j++) checkOutput($sformatf("rr_gap%0d", j), gaps[j], 1);

    // Burst hold: master 2 keeps the slave for four beats while master 0 waits.
    doReset();
    tick();
    applyStimulus(2, 1'b1, 1'b1, 32'h300, 3'b010);
    tick();
    for (int b = 0; b < 4; b++) begin
      applyStimulus(2, 1'b1, 1'b1, 32'h300 + 4 * b, (b == 3) ? 3'b111 : 3'b010);
      applyStimulus(0, 1'b1, 1'b1, 32'h0, 3'b000);
      slaveResp(1'b1, 1'b0, 1'b0, 32'hB0 + b);
      settle();
      checkOutput($sformatf("burst_grant%0d", b), grant, 3'b100);
      checkOutput($sformatf("burst_ack%0d", b), bus.m_ack_o, 3'b100);
      if (b == 3) checkOutput("burst_cti_end", bus.s_cti_o, 3'b111);
      tick();
    end
    applyStimulus(2, 1'b0, 1'b0, 32'h0, 3'b000);
    slaveResp(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("burst_still_m2", grant, 3'b100);
    tick(); settle();
    checkOutput("burst_idle_gap", grant, 0);
    tick(); settle();
    checkOutput("burst_m0_next", grant, 3'b001);

    // Watchdog: master 0 is never answered, master 1 waits behind it.
    doReset();
    tick();
    applyStimulus(0, 1'b1, 1'b1, 32'h400, 3'b000);
    applyStimulus(1, 1'b1, 1'b1, 32'h500, 3'b000);
    for (int k = 1; k <= 17; k++) begin
      tick(); settle();
      if (k == 1) checkOutput("wd_grant", grant, 3'b001);
      if (k < 17) checkOutput($sformatf("wd_quiet%0d", k), {timeout, bus.m_err_o, bus.s_cyc_o}, {1'b0, 3'b000, 1'b1});
    end
    checkOutput("wd_err", bus.m_err_o, 3'b001);
    checkOutput("wd_timeout", timeout, 1);
    checkOutput("wd_cyc_drop", {bus.s_cyc_o, bus.s_stb_o}, 0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 3'b000);
    settle();
    checkOutput("wd_pulse_end", {timeout, bus.m_err_o, bus.s_cyc_o}, 0);
    checkOutput("wd_hold_owner", grant, 3'b001);
    tick(); settle();
    checkOutput("wd_idle", grant, 0);
    tick(); settle();
    checkOutput("wd_m1_grant", grant, 3'b010);
    checkOutput("wd_m1_cyc", bus.s_cyc_o, 1);

    // Ack on the last cycle before the watchdog would fire.
    doReset();
    tick();
    applyStimulus(0, 1'b1, 1'b1, 32'h600, 3'b000);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 16) slaveResp(1'b1, 1'b0, 1'b0, 32'h12345678);
      settle();
    end
    checkOutput("race_ack", bus.m_ack_o, 3'b001);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 3'b000);
    slaveResp(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("race_no_err", {timeout, bus.m_err_o}, 0);
    tick(); settle();
    checkOutput("race_released", {timeout, grant}, 0);

    // Reset during a burst beat, then master 0 wins first.
    doReset();
    tick();
    applyStimulus(2, 1'b1, 1'b1, 32'h700, 3'b010);
    tick();
    applyStimulus(0, 1'b1, 1'b1, 32'h0, 3'b000);
    applyStimulus(1, 1'b1, 1'b1, 32'h0, 3'b000);
    slaveResp(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("mid_beat_ack", bus.m_ack_o, 3'b100);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_grant", grant, 0);
    checkOutput("mid_rst_s", {bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o}, 0);
    checkOutput("mid_rst_m_resp", {timeout, bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
    tick();
    rst_n = 1'b1;
    slaveResp(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); settle();
    checkOutput("post_rst_m0_first", grant, 3'b001);

    // Random traffic against the reference model.
    doReset();
    silent = 0;
    for (int c = 0; c < 1500; c++) randomCycle();
    $display("[TB] random phase saw %0d watchdog aborts", aborts);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
